// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// default address/data widths.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for the two requesters.
// Optional macro RAM_ARB_RR_EN: ties alternate; otherwise requester 0 wins ties.
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
`ifdef RAM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
`ifdef RAM_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = req1;
    end
`else
    winner = ~req0 & req1;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM; one access
// every four cycles. Optional macro RAM_ARB_RR_EN selects round-robin ties.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [3:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic [3:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  arb_state_t        state_reg, state_next;
  logic              grant_reg;
  logic [3:0]        we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              any_req;
  logic              winner;
  logic              take_grant;
  logic [3:0]        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [DATA_W-1:0] rdata_arr [2];
  logic              ready_arr [2];

`ifdef RAM_ARB_RR_EN
  logic last_grant_reg;

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (take_grant) begin
      last_grant_reg <= winner;
    end
  end
`endif

  ram_arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
`ifdef RAM_ARB_RR_EN
    .last_grant (last_grant_reg),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  assign take_grant = (state_reg == ST_IDLE) && any_req;
  assign sel_we     = winner ? m1_we    : m0_we;
  assign sel_addr   = winner ? m1_addr  : m0_addr;
  assign sel_wdata  = winner ? m1_wdata : m0_wdata;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_WAIT;
      ST_WAIT:   state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Requester inputs are captured only at grant, so later changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= 1'b0;
      we_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take_grant) begin
        grant_reg <= winner;
        we_reg    <= sel_we;
        addr_reg  <= sel_addr;
        wdata_reg <= sel_wdata;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;

      // RAM data for the read issued in ACCESS is valid during WAIT.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if ((state_reg == ST_WAIT) && (grant_reg == 1'(gi)) && (we_reg == 4'd0)) begin
          rdata_reg <= ram_douta;
        end
      end

      assign rdata_arr[gi] = rdata_reg;
      assign ready_arr[gi] = (state_reg == ST_DONE) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign m0_rdata  = rdata_arr[0];
  assign m1_rdata  = rdata_arr[1];
  assign m0_ready  = ready_arr[0];
  assign m1_ready  = ready_arr[1];

  assign ram_wea   = (state_reg == ST_ACCESS) ? we_reg : 4'd0;
  assign ram_addra = addr_reg;
  assign ram_dina  = wdata_reg;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Signal clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Signal rst, input, 1, reset, synchronous and active-high.
REQ-005 Signal m0_req, input, 1, requester 0 (CPU data port) access request, held high until m0_ready.
REQ-006 Signal m0_we, input, 4, requester 0 byte write enables; all-zero means read.
REQ-007 Signal m0_addr, input, ADDR_W, requester 0 word address.
REQ-008 Signal m0_wdata, input, DATA_W, requester 0 write data.
REQ-009 Signal m0_rdata, output, DATA_W, requester 0 read data, valid while m0_ready=1.
REQ-010 Signal m0_ready, output, 1, requester 0 completion pulse.
REQ-011 Signals m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready SHALL mirror REQ-005..010 for requester 1 (loader/DMA).
REQ-012 Signal ram_wea, output, 4, RAM byte write enables.
REQ-013 Signal ram_addra, output, ADDR_W, RAM address.
REQ-014 Signal ram_dina, output, DATA_W, RAM write data.
REQ-015 Signal ram_douta, input, DATA_W, RAM read data, one-cycle synchronous latency on clk.

Function
REQ-016 FSM states: IDLE, ACCESS, WAIT, DONE; transitions IDLE->ACCESS when any req=1, ACCESS->WAIT, WAIT->DONE, DONE->IDLE, all unconditional except IDLE.
REQ-017 In IDLE with a request, the block registers the winner's index, we, addr, wdata.
REQ-018 In ACCESS, ram_addra/ram_dina/ram_wea come from the latched values; ram_wea SHALL be 0 in every other state.
REQ-019 In WAIT, ram_addra holds the latched address; on the WAIT->DONE edge, the winner's rdata register loads ram_douta only if latched we==0.
REQ-020 In DONE, exactly the winner's ready is 1 for one cycle; the loser's ready stays 0.
REQ-021 Latency: req sampled in IDLE at edge N -> ready high during cycle N+3; one access per 4 cycles.
REQ-022 Requester inputs other than req are ignored outside IDLE; changes mid-access do not affect the transaction.
REQ-023 A req still high in IDLE after DONE is a new request.
REQ-024 Writes leave the winner's rdata unchanged; the non-winner's rdata is never modified.
REQ-025 Simultaneous m0_req and m1_req in IDLE are resolved per REQ-029/030.
REQ-026 req dropped by the requester mid-access: transaction still completes, ready still pulses.

Reset
REQ-027 rst=1 at any edge, including mid-access: state=IDLE, ram_wea=0, ram_addra=0, ram_dina=0, m0/m1_ready=0, m0/m1_rdata=0, latches=0, last-grant pointer=1.
REQ-028 An access interrupted by reset is dropped; no ready pulse follows.

Configuration
REQ-029 With RAM_ARB_RR_EN defined, ties go to the requester not granted last (pointer updates on every grant; after reset m0 wins the first tie).
REQ-030 Without RAM_ARB_RR_EN, fixed priority: m0 always wins ties, pointer register omitted.

Structure
REQ-031 Package ram_arb_pkg holds the FSM state enum and default ADDR_W/DATA_W constants.
REQ-032 One sub-module ram_arb_pick: combinational winner selection from req pair and pointer, macro-dependent.

Verification
REQ-033 Single read: RAM[5]=32'hDEADBEEF, m0 reads addr 5 -> m0_ready high 3 cycles after sampling, m0_rdata=32'hDEADBEEF, ram_wea=0 throughout.
REQ-034 Byte write: m1_we=4'b0010, addr 7, wdata 32'h0000AB00 -> ram_wea=4'b0010 exactly one cycle (ACCESS), m1_rdata unchanged, m1_ready pulse once.
REQ-035 Tie with RAM_ARB_RR_EN: both req held continuously after reset -> grants alternate m0,m1,m0,m1; without macro -> m0 only, m1 starves.
REQ-036 Reset mid-access: rst asserted in WAIT -> next cycle IDLE, no ready pulse, all outputs 0.
REQ-037 Input change: m0_addr changes from 3 to 9 during ACCESS -> ram_addra stays 3, rdata from addr 3.
REQ-038 Back-to-back: m0_req held high through DONE -> second access starts in following IDLE, two ready pulses 4 cycles apart.
